// File: rtl/multicycle_ctrl_if.sv
// Control bundle between the multi-cycle FSM and the datapath/memory.
// master: FSM side (drives controls); slave: datapath side.
interface multicycle_ctrl_if #(
  parameter int CNT_W = 32
);
  logic [5:0]       opcode_i;
  logic             mem_ready_i;
  logic             mem_req_o;
  logic             mem_we_o;
  logic             iord_o;
  logic             ir_write_o;
  logic             pc_write_o;
  logic             pc_write_cond_o;
  logic [1:0]       pc_src_o;
  logic [1:0]       branch_type_o;
  logic             alu_src_a_o;
  logic [1:0]       alu_src_b_o;
  logic [2:0]       alu_op_o;
  logic             reg_write_o;
  logic             reg_dst_o;
  logic             mem_to_reg_o;
  logic [2:0]       state_o;
  logic [CNT_W-1:0] retired_o;
  logic             illegal_o;

  modport master (
    input  opcode_i, mem_ready_i,
    output mem_req_o, mem_we_o, iord_o,
    output ir_write_o, pc_write_o,
    output pc_write_cond_o, pc_src_o,
    output branch_type_o, alu_src_a_o,
    output alu_src_b_o, alu_op_o,
    output reg_write_o, reg_dst_o,
    output mem_to_reg_o, state_o,
    output retired_o, illegal_o
  );

  modport slave (
    output opcode_i, mem_ready_i,
    input  mem_req_o, mem_we_o, iord_o,
    input  ir_write_o, pc_write_o,
    input  pc_write_cond_o, pc_src_o,
    input  branch_type_o, alu_src_a_o,
    input  alu_src_b_o, alu_op_o,
    input  reg_write_o, reg_dst_o,
    input  mem_to_reg_o, state_o,
    input  retired_o, illegal_o
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multi-cycle MIPS-subset main control FSM with retire counter and trap.
// Ports: clk_i, rst_i (sync, active high), bus (multicycle_ctrl_if.master).
module multicycle_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic               clk_i,
  input  logic               rst_i,
  multicycle_ctrl_if.master  bus
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd7
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic             retire;

  logic [5:0] op;
  logic       is_r, is_j, is_br, is_imm;
  logic       is_lw, is_sw, is_ls, legal;

  assign op     = bus.opcode_i;
  assign is_r   = (op == 6'd0);
  assign is_j   = (op == 6'd2);
  assign is_br  = (op inside {6'd4, 6'd5, 6'd6, 6'd7});
  assign is_imm = (op inside {6'd8, 6'd11, 6'd13, 6'd15});
  assign is_lw  = (op == 6'd35);
  assign is_sw  = (op == 6'd43);
  assign is_ls  = is_lw | is_sw;
  assign legal  = is_r | is_br | is_imm | is_ls;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= S_FETCH;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      retired_q <= retired_d;
    end
  end

  always_comb begin
    state_d             = state_q;
    retire              = 1'b0;
    bus.mem_req_o       = 1'b0;
    bus.mem_we_o        = 1'b0;
    bus.iord_o          = 1'b0;
    bus.ir_write_o      = 1'b0;
    bus.pc_write_o      = 1'b0;
    bus.pc_write_cond_o = 1'b0;
    bus.pc_src_o        = 2'b00;
    bus.branch_type_o   = 2'b00;
    bus.alu_src_a_o     = 1'b0;
    bus.alu_src_b_o     = 2'b00;
    bus.alu_op_o        = 3'b101;
    bus.reg_write_o     = 1'b0;
    bus.reg_dst_o       = 1'b0;
    bus.mem_to_reg_o    = 1'b0;

    unique case (state_q)
      S_FETCH: begin
        bus.mem_req_o   = 1'b1;
        bus.alu_src_b_o = 2'b01;
        if (bus.mem_ready_i) begin
          bus.ir_write_o = 1'b1;
          bus.pc_write_o = 1'b1;
          state_d        = S_DECODE;
        end
      end
      S_DECODE: begin
        // ALUOut captures PC+4 + (imm<<2) for a possible branch
        bus.alu_src_b_o = 2'b11;
        if (is_j) begin
          bus.pc_write_o = 1'b1;
          bus.pc_src_o   = 2'b10;
          retire         = 1'b1;
          state_d        = S_FETCH;
        end else if (legal) begin
          state_d = S_EXEC;
        end else begin
          state_d = S_TRAP;
        end
      end
      S_EXEC: begin
        bus.alu_src_a_o = 1'b1;
        unique case (1'b1)
          is_r: begin
            bus.alu_op_o = 3'b000;
            state_d      = S_WB;
          end
          is_imm: begin
            bus.alu_src_b_o = 2'b10;
            unique case (op)
              6'd8:    bus.alu_op_o = 3'b001;
              6'd11:   bus.alu_op_o = 3'b010;
              6'd13:   bus.alu_op_o = 3'b111;
              default: bus.alu_op_o = 3'b011;
            endcase
            state_d = S_WB;
          end
          is_ls: begin
            bus.alu_src_b_o = 2'b10;
            state_d         = S_MEM;
          end
          is_br: begin
            bus.alu_op_o        = 3'b110;
            bus.pc_write_cond_o = 1'b1;
            bus.pc_src_o        = 2'b01;
            bus.branch_type_o   = op[1:0];
            retire              = 1'b1;
            state_d             = S_FETCH;
          end
          default: state_d = S_TRAP;
        endcase
      end
      S_MEM: begin
        bus.mem_req_o = 1'b1;
        bus.iord_o    = 1'b1;
        bus.mem_we_o  = is_sw;
        if (bus.mem_ready_i) begin
          if (is_sw) begin
            retire  = 1'b1;
            state_d = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end
      end
      S_WB: begin
        bus.reg_write_o  = 1'b1;
        bus.reg_dst_o    = is_r;
        bus.mem_to_reg_o = is_lw;
        retire           = 1'b1;
        state_d          = S_FETCH;
      end
      S_TRAP: begin
        bus.alu_op_o = 3'b000;
      end
      default: state_d = S_FETCH;
    endcase
  end

  assign retired_d     = retire ? retired_q + 1'b1 : retired_q;
  assign bus.state_o   = state_q;
  assign bus.retired_o = retired_q;
  assign bus.illegal_o = (state_q == S_TRAP);

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Main control FSM for the multi-cycle variant of the single-cycle MIPS-subset CPU.
- Sequences one shared ALU and one unified instruction/data memory through FETCH/DECODE/EXEC/MEM/WB.
- Memory has a req/ready handshake, so accesses may stall for any number of cycles.
- Also counts retired instructions and traps on unsupported opcodes.

Parameters:
CNT_W, 32, width of retired-instruction counter

Ports:
clk_i  in  1  clock, all state updates on rising edge
rst_i  in  1  synchronous active-high reset
opcode_i  in  6  IR[31:26] from instruction register (valid from DECODE onward)
mem_ready_i  in  1  memory completes current access this cycle
mem_req_o  out  1  memory access request
mem_we_o  out  1  memory write (sw only)
iord_o  out  1  memory address select: 0=PC, 1=ALUOut
ir_write_o  out  1  load instruction register
pc_write_o  out  1  unconditional PC load
pc_write_cond_o  out  1  PC load if branch condition true (evaluated in datapath)
pc_src_o  out  2  00=ALU result, 01=ALUOut (branch target), 10=jump target
branch_type_o  out  2  00 beq, 01 bne, 10 blez, 11 bgtz
alu_src_a_o  out  1  0=PC, 1=rs
alu_src_b_o  out  2  00=rt, 01=const 4, 10=sign-ext imm, 11=sign-ext imm<<2
alu_op_o  out  3  same encoding as single-cycle decoder; add=101
reg_write_o  out  1  register-file write
reg_dst_o  out  1  1=rd, 0=rt
mem_to_reg_o  out  1  1=memory data register, 0=ALUOut
state_o  out  3  current state, for debug/bench
retired_o  out  CNT_W  retired-instruction count
illegal_o  out  1  trap flag

Behaviour:
- States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=7.
- Reset (rst_i high at clock edge): state=FETCH, retired_o=0, illegal_o=0. Reset overrides everything, including mid-access and TRAP. A pending memory request is simply dropped.
- All control outputs are combinational from state and opcode_i. Any output not listed for a state is 0; alu_op_o defaults to 101.
- FETCH:
  - mem_req_o=1, iord_o=0, alu_src_a_o=0, alu_src_b_o=01.
  - Stays in FETCH while mem_ready_i=0.
  - When mem_ready_i=1: ir_write_o=1 and pc_write_o=1 (pc_src_o=00, PC+4) in the same cycle, then go to DECODE.
- DECODE:
  - alu_src_a_o=0, alu_src_b_o=11 (branch target precompute).
  - opcode 2 (j): pc_write_o=1, pc_src_o=10; retire; go to FETCH.
  - Legal opcodes (0, 4, 5, 6, 7, 8, 11, 13, 15, 35, 43): go to EXEC.
  - Any other opcode: go to TRAP.
- EXEC:
  - R-type: alu_src_a_o=1, alu_src_b_o=00, alu_op_o=000; go to WB.
  - addi/sltiu/ori/lui: alu_src_a_o=1, alu_src_b_o=10, alu_op_o=001/010/111/011; go to WB.
  - lw/sw: alu_src_a_o=1, alu_src_b_o=10, alu_op_o=101; go to MEM.
  - Branch (4/5/6/7): alu_src_a_o=1, alu_src_b_o=00, alu_op_o=110, pc_write_cond_o=1, pc_src_o=01, branch_type_o=00/01/10/11; retire; go to FETCH.
- MEM:
  - mem_req_o=1, iord_o=1, mem_we_o=1 for sw only.
  - Stays in MEM until mem_ready_i=1.
  - On ready: sw retires and goes to FETCH; lw goes to WB.
  - mem_we_o stays high for the whole stall. Memory must commit the write exactly once, on the ready cycle.
- WB:
  - reg_write_o=1.
  - R-type: reg_dst_o=1. I-type: reg_dst_o=0. lw: reg_dst_o=0, mem_to_reg_o=1.
  - Retire; go to FETCH.
- TRAP: all control outputs 0, illegal_o=1. Stays in TRAP until reset; retired_o is frozen.
- Retire: retired_o increments by 1 on the state-leaving edge. It wraps modulo 2^CNT_W with no flag.
- Handshake rules:
  - mem_req_o never drops before a ready is seen.
  - mem_ready_i is ignored in DECODE, EXEC, WB and TRAP.
  - mem_ready_i already high on the first request cycle completes the access in 1 cycle.
- Cycles per instruction with zero wait: j 2; branch 3; R/I 4; sw 4; lw 5. Each wait cycle adds 1.

Test Plan:
- Reset mid-access: assert rst_i during MEM stall of lw -> next cycle state_o=0, mem_req_o=1, iord_o=0, retired_o=0.
- Zero-wait sequence add, addi, lw, sw, beq, j with mem_ready_i tied 1 -> state traces 0,1,2,4 / 0,1,2,4 / 0,1,2,3,4 / 0,1,2,3 / 0,1,2 / 0,1; retired_o=6 after 22 cycles.
- Fetch stall of 3 cycles -> mem_req_o=1 and ir_write_o=0 for 3 cycles; ir_write_o=pc_write_o=1 exactly once, on the ready cycle.
- sw with 2 wait cycles -> mem_we_o=1, iord_o=1 for 3 cycles; state returns to FETCH; reg_write_o never 1.
- bgtz -> EXEC shows pc_write_cond_o=1, pc_src_o=01, branch_type_o=11, alu_op_o=110; pc_write_o=0.
- opcode 6'h3F -> TRAP after DECODE; illegal_o=1; outputs 0 for 10 cycles; retired_o unchanged; rst_i clears it.
